led_sandbox_multi_timer: RTL and testbench
==========================================

// Module: led_sandbox_multi_timer
// PURPOSE
//   Parametrised successor to the single-channel systick interval timer: NUM_CH independent
//   down-counting timers with per-channel prescaler behind one Avalon-MM slave. Sits on the
//   SOPC system bus and provides systick plus LED-effect timebases. Per-channel irq vector
//   and OR-reduced irq for the CPU.
// PARAMETERS
//   NUM_CH       4         number of timer channels, 1..8
//   CNT_W        32        counter/period width, 8..32
//   PRE_W        16        prescaler width; tick every (PRESCALE+1) clk
//   RESET_PERIOD 99999     reset value of every PERIOD register and counter
// PORTS
//   clk        in   1                  system clock; single clock domain
//   reset      in   1                  synchronous, active-high reset
//   address    in   $clog2(NUM_CH)+3   {channel, word offset[2:0]}
//   chipselect in   1                  slave select
//   write_n    in   1                  active-low write strobe, qualified by chipselect
//   writedata  in   32                 write data
//   readdata   out  32                 registered read data
//   irq        out  1                  OR of irq_vec
//   irq_vec    out  NUM_CH             per-channel TO && ITO
//   pwm_out    out  NUM_CH             compare outputs; tied 0 without the macro
// BEHAVIOUR
//   Word map per channel: 0 STATUS {RUN[1],TO[0]}; 1 CONTROL {STOP[3],START[2],CONT[1],ITO[0]};
//     2 PERIOD[CNT_W-1:0]; 3 SNAP; 4 PRESCALE[PRE_W-1:0]; 5 COMPARE (macro only); 6,7 read 0.
//   Reset: counter=period=RESET_PERIOD, prescale=0, control=0, RUN=0, TO=0, snapshot=0,
//     readdata=0, irq=0, irq_vec=0, pwm_out=0.
//   Read latency 1 cycle: readdata reflects the address presented in the previous cycle.
//     Unused bits read 0; channel index >= NUM_CH reads 0, writes ignored.
//   Prescaler: counts 0..PRESCALE while RUN; tick=1 on wrap. PRESCALE=0 -> tick every clk.
//     Cleared on START, PERIOD write, PRESCALE write.
//   Counter: on tick, 0 -> reload PERIOD, else decrement. Holds while RUN=0.
//   Timeout: tick && counter==0 sets TO (one event per reload, PERIOD=0 -> TO every tick).
//     CONT=0: same tick clears RUN, counter reloads PERIOD. CONT=1: keeps running.
//   STATUS write (any data) clears TO; same-cycle timeout wins (TO stays 1).
//   CONTROL write stores bits [1:0]; START sets RUN; STOP clears RUN; both set -> START wins.
//   PERIOD write: next cycle counter=new PERIOD, RUN=0, prescaler=0 (force reload + stop).
//   SNAP write (any data) captures live counter; SNAP read returns captured value.
//   Reset mid-count: all state to reset values in the next cycle, no residual irq.
//   Widths: writedata truncated to field width; counter math modulo 2^CNT_W, never wraps past 0.
// CONFIGURATION
//   MULTI_TIMER_PWM_EN defined: COMPARE reg per channel (reset 0, CNT_W bits);
//     pwm_out[i] = RUN && (counter < COMPARE), registered (1-cycle latency).
//   Undefined: no COMPARE storage, word 5 reads 0, writes ignored, pwm_out held 0.
// STRUCTURE
//   Package multi_timer_pkg: word offsets (STATUS..COMPARE), CONTROL/STATUS bit indices,
//     address split helper constants.
//   Sub-module multi_timer_channel: one counter+prescaler+regs, generate-instanced NUM_CH times;
//     top holds address decode, read mux, readdata register, irq reduce.
// TESTING
//   Reset: readdata=0, irq=0; read ch0 PERIOD -> 99999, STATUS -> 0.
//   ch1 PERIOD=4, PRESCALE=0, CONTROL=0x6 (START|CONT): TO every 5 clk; CONTROL=0x7 -> irq_vec[1]=1.
//   ch2 PERIOD=2, PRESCALE=3, CONTROL=0x4: TO after 12 clk, RUN=0, counter=2.
//   STATUS write same cycle as timeout -> TO stays 1; next STATUS write -> TO=0, irq=0.
//   Running ch0, PERIOD write 10 -> RUN=0, counter=10; SNAP write then read -> 10.
//   PWM_EN: PERIOD=9, COMPARE=3, START|CONT -> pwm_out[0] high 3 of every 10 clk; else 0.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel timer.
//   Word offsets within a channel's 8-word window, CONTROL/STATUS bit
//   positions, and the helper that sizes the bus address.
package multi_timer_pkg;

   localparam int WORD_W = 3;

   localparam logic [2:0] WORD_STATUS   = 3'd0;
   localparam logic [2:0] WORD_CONTROL  = 3'd1;
   localparam logic [2:0] WORD_PERIOD   = 3'd2;
   localparam logic [2:0] WORD_SNAP     = 3'd3;
   localparam logic [2:0] WORD_PRESCALE = 3'd4;
   localparam logic [2:0] WORD_COMPARE  = 3'd5;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   localparam int STAT_TO  = 0;
   localparam int STAT_RUN = 1;

   // Bus address is {channel index, word offset}.
   function automatic int addr_w(input int num_ch);
      return $clog2(num_ch) + WORD_W;
   endfunction

endpackage

// File: rtl/led_sandbox_multi_timer_channel.sv
// One timer channel: prescaler, down-counter, and its register file.
//   Optional feature macro: MULTI_TIMER_PWM_EN (adds COMPARE register and
//   registered pwm output; otherwise pwm is tied 0 and word 5 reads 0).
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   wr_en               write strobe already decoded for this channel
//   wr_word, wr_data    word offset and data of the write
//   rd_word             word offset being read
//   rd_data             combinational read value for rd_word
//   irq                 TO && ITO
//   pwm                 compare output
module multi_timer_channel
   import multi_timer_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int PRE_W        = 16,
   parameter int RESET_PERIOD = 99999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [2:0]  wr_word,
   input  logic [31:0] wr_data,
   input  logic [2:0]  rd_word,
   output logic [31:0] rd_data,
   output logic        irq,
   output logic        pwm
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] snap_q, snap_d;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PRE_W-1:0] prescale_q, prescale_d;
   logic             run_q, run_d;
   logic             to_q, to_d;
   logic             ito_q, ito_d;
   logic             cont_q, cont_d;

   logic tick, timeout;
   logic wr_status, wr_control, wr_period, wr_snap, wr_prescale;

   always_comb begin
      wr_status   = wr_en && (wr_word == WORD_STATUS);
      wr_control  = wr_en && (wr_word == WORD_CONTROL);
      wr_period   = wr_en && (wr_word == WORD_PERIOD);
      wr_snap     = wr_en && (wr_word == WORD_SNAP);
      wr_prescale = wr_en && (wr_word == WORD_PRESCALE);

      tick    = run_q && (pre_cnt_q == prescale_q);
      timeout = tick && (cnt_q == '0);

      cnt_d      = cnt_q;
      period_d   = period_q;
      snap_d     = snap_q;
      pre_cnt_d  = pre_cnt_q;
      prescale_d = prescale_q;
      run_d      = run_q;
      to_d       = to_q;
      ito_d      = ito_q;
      cont_d     = cont_q;

      // Prescaler restarts from 0 whenever the timebase is reprogrammed or restarted.
      if ((wr_control && wr_data[CTRL_START]) || wr_period || wr_prescale) begin
         pre_cnt_d = '0;
      end else if (run_q) begin
         pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
      end

      if (tick) begin
         cnt_d = (cnt_q == '0) ? period_q : cnt_q - CNT_W'(1);
      end

      // Later assignments take priority: timeout stop, then CONTROL, then PERIOD.
      if (timeout && !cont_q) begin
         run_d = 1'b0;
      end
      if (wr_control) begin
         ito_d  = wr_data[CTRL_ITO];
         cont_d = wr_data[CTRL_CONT];
         if (wr_data[CTRL_START]) begin
            run_d = 1'b1;
         end else if (wr_data[CTRL_STOP]) begin
            run_d = 1'b0;
         end
      end
      if (wr_period) begin
         period_d = wr_data[CNT_W-1:0];
         cnt_d    = wr_data[CNT_W-1:0];
         run_d    = 1'b0;
      end

      if (wr_prescale) begin
         prescale_d = wr_data[PRE_W-1:0];
      end
      if (wr_snap) begin
         snap_d = cnt_q;
      end

      // A timeout in the same cycle as a clear must not be lost.
      if (wr_status) begin
         to_d = 1'b0;
      end
      if (timeout) begin
         to_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= CNT_W'(RESET_PERIOD);
         period_q   <= CNT_W'(RESET_PERIOD);
         snap_q     <= '0;
         pre_cnt_q  <= '0;
         prescale_q <= '0;
         run_q      <= 1'b0;
         to_q       <= 1'b0;
         ito_q      <= 1'b0;
         cont_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         snap_q     <= snap_d;
         pre_cnt_q  <= pre_cnt_d;
         prescale_q <= prescale_d;
         run_q      <= run_d;
         to_q       <= to_d;
         ito_q      <= ito_d;
         cont_q     <= cont_d;
      end
   end

   assign irq = to_q && ito_q;

`ifdef MULTI_TIMER_PWM_EN
   logic [CNT_W-1:0] compare_q, compare_d;
   logic             pwm_q, pwm_d;

   always_comb begin
      compare_d = compare_q;
      if (wr_en && (wr_word == WORD_COMPARE)) begin
         compare_d = wr_data[CNT_W-1:0];
      end
      pwm_d = run_q && (cnt_q < compare_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         compare_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         compare_q <= compare_d;
         pwm_q     <= pwm_d;
      end
   end

   assign pwm = pwm_q;
`else
   assign pwm = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      case (rd_word)
         WORD_STATUS:   rd_data = {30'd0, run_q, to_q};
         WORD_CONTROL:  rd_data = {30'd0, cont_q, ito_q};
         WORD_PERIOD:   rd_data = 32'(period_q);
         WORD_SNAP:     rd_data = 32'(snap_q);
         WORD_PRESCALE: rd_data = 32'(prescale_q);
`ifdef MULTI_TIMER_PWM_EN
         WORD_COMPARE:  rd_data = 32'(compare_q);
`endif
         default:       rd_data = '0;
      endcase
   end

endmodule

// File: rtl/led_sandbox_multi_timer.sv
// NUM_CH independent prescaled down-counting timers behind one Avalon-MM slave.
//   Optional feature macro: MULTI_TIMER_PWM_EN (per-channel COMPARE / pwm_out).
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   address           {channel index, word offset[2:0]}
//   chipselect        slave select
//   write_n           active-low write strobe, qualified by chipselect
//   writedata         write data
//   readdata          registered read data (1-cycle latency)
//   irq               OR of irq_vec
//   irq_vec           per-channel TO && ITO
//   pwm_out           per-channel compare outputs
module led_sandbox_multi_timer
   import multi_timer_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 32,
   parameter int PRE_W        = 16,
   parameter int RESET_PERIOD = 99999
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [addr_w(NUM_CH)-1:0]  address,
   input  logic                       chipselect,
   input  logic                       write_n,
   input  logic [31:0]                writedata,
   output logic [31:0]                readdata,
   output logic                       irq,
   output logic [NUM_CH-1:0]          irq_vec,
   output logic [NUM_CH-1:0]          pwm_out
);

   logic [31:0] addr_ch;
   logic [2:0]  addr_word;
   logic        ch_valid;
   logic [31:0] readdata_q, readdata_d;

   logic [31:0] ch_rd  [NUM_CH];
   logic        ch_irq [NUM_CH];
   logic        ch_pwm [NUM_CH];
   logic        ch_wr  [NUM_CH];

   always_comb begin
      addr_ch   = 32'(address >> WORD_W);
      addr_word = address[2:0];
      // Channel fields beyond NUM_CH exist when NUM_CH is not a power of two.
      ch_valid  = addr_ch < 32'(NUM_CH);
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign ch_wr[g] = chipselect && !write_n && ch_valid && (addr_ch == 32'(g));

      multi_timer_channel #(
         .CNT_W        (CNT_W),
         .PRE_W        (PRE_W),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (ch_wr[g]),
         .wr_word (addr_word),
         .wr_data (writedata),
         .rd_word (addr_word),
         .rd_data (ch_rd[g]),
         .irq     (ch_irq[g]),
         .pwm     (ch_pwm[g])
      );
   end

   always_comb begin
      readdata_d = '0;
      irq_vec    = '0;
      pwm_out    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (chipselect && ch_valid && (addr_ch == 32'(i))) begin
            readdata_d = ch_rd[i];
         end
         irq_vec[i] = ch_irq[i];
         pwm_out[i] = ch_pwm[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_q <= '0;
      end else begin
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |irq_vec;

endmodule

// File: tb/tb_led_sandbox_multi_timer.sv
module tb_led_sandbox_multi_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   logic [3:0]  irq_vec;
   logic [3:0]  pwm_out;

   int checks = 0;
   int passed = 0;

   led_sandbox_multi_timer dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .irq_vec    (irq_vec),
      .pwm_out    (pwm_out)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int ch, input int word, input logic [31:0] data);
      address    = 5'(ch * 8 + word);
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = data;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic rd(input int ch, input int word, output logic [31:0] data);
      address    = 5'(ch * 8 + word);
      chipselect = 1'b1;
      write_n    = 1'b1;
      @(posedge clk);
      #1;
      data       = readdata;
      chipselect = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      tick(3);
      checks++;
      if (readdata !== 32'd0 || irq !== 1'b0 || irq_vec !== 4'd0 || pwm_out !== 4'd0)
         $display("FAIL reset_outputs: rd=%h irq=%b vec=%b pwm=%b want all 0", readdata, irq, irq_vec, pwm_out);
      else passed++;
      reset = 1'b0;
      rd(0, 2, d);
      checks++;
      if (d !== 32'd99999) $display("FAIL reset_period: got %0d want 99999", d);
      else passed++;
      rd(0, 0, d);
      checks++;
      if (d !== 32'd0) $display("FAIL reset_status: got %h want 0", d);
      else passed++;
      rd(2, 3, d);
      checks++;
      if (d !== 32'd0) $display("FAIL reset_snap: got %h want 0", d);
      else passed++;
      rd(1, 6, d);
      checks++;
      if (d !== 32'd0) $display("FAIL word6_zero: got %h want 0", d);
      else passed++;
   endtask

   task automatic test_periodic();
      logic [31:0] d;
      wr(1, 4, 32'd0);
      wr(1, 2, 32'd4);
      wr(1, 1, 32'h6);          // P0: START|CONT, no irq enable
      tick(6);                  // timeout at P5 happened, masked
      checks++;
      if (irq_vec !== 4'b0000 || irq !== 1'b0)
         $display("FAIL ito_mask: vec=%b irq=%b want 0", irq_vec, irq);
      else passed++;
      rd(1, 0, d);              // P7
      checks++;
      if (d !== 32'h3) $display("FAIL periodic_status: got %h want 3", d);
      else passed++;
      wr(1, 1, 32'h7);          // P8
      checks++;
      if (irq_vec !== 4'b0010 || irq !== 1'b1)
         $display("FAIL ito_enable: vec=%b irq=%b want 0010/1", irq_vec, irq);
      else passed++;
      wr(1, 0, 32'd0);          // P9 clear
      checks++;
      if (irq_vec !== 4'b0000) $display("FAIL status_clear: vec=%b want 0000", irq_vec);
      else passed++;
      tick(1);                  // P10 timeout
      checks++;
      if (irq_vec !== 4'b0010) $display("FAIL periodic_p10: vec=%b want 0010", irq_vec);
      else passed++;
      wr(1, 0, 32'd0);          // P11 clear
      tick(3);                  // P14
      checks++;
      if (irq_vec !== 4'b0000) $display("FAIL periodic_early: vec=%b want 0000", irq_vec);
      else passed++;
      wr(1, 0, 32'd0);          // P15: clear collides with timeout
      checks++;
      if (irq_vec !== 4'b0010 || irq !== 1'b1)
         $display("FAIL clear_vs_timeout: vec=%b irq=%b want 0010/1", irq_vec, irq);
      else passed++;
      wr(1, 0, 32'd0);          // P16
      checks++;
      if (irq_vec !== 4'b0000 || irq !== 1'b0)
         $display("FAIL clear_after: vec=%b irq=%b want 0000/0", irq_vec, irq);
      else passed++;
      wr(1, 1, 32'h8);          // P17 STOP
      rd(1, 0, d);
      checks++;
      if (d !== 32'h0) $display("FAIL stop_status: got %h want 0", d);
      else passed++;
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      wr(2, 2, 32'd2);
      wr(2, 4, 32'd3);
      wr(2, 1, 32'h4);          // Q0: START, one-shot
      tick(11);                 // Q11
      rd(2, 0, d);              // state before Q12
      checks++;
      if (d !== 32'h2) $display("FAIL oneshot_pre: got %h want 2", d);
      else passed++;
      rd(2, 0, d);              // state after Q12 timeout
      checks++;
      if (d !== 32'h1) $display("FAIL oneshot_to: got %h want 1", d);
      else passed++;
      wr(2, 3, 32'd0);
      rd(2, 3, d);
      checks++;
      if (d !== 32'd2) $display("FAIL oneshot_reload: got %0d want 2", d);
      else passed++;
   endtask

   task automatic test_period_write();
      logic [31:0] d;
      wr(0, 1, 32'h4);          // R0 START
      tick(2);
      wr(0, 3, 32'd0);          // R3 snap
      rd(0, 3, d);
      checks++;
      if (d !== 32'd99997) $display("FAIL snap_running: got %0d want 99997", d);
      else passed++;
      wr(0, 2, 32'd10);
      rd(0, 0, d);
      checks++;
      if (d !== 32'h0) $display("FAIL period_stops: got %h want 0", d);
      else passed++;
      wr(0, 3, 32'd0);
      rd(0, 3, d);
      checks++;
      if (d !== 32'd10) $display("FAIL period_reload: got %0d want 10", d);
      else passed++;
   endtask

   task automatic test_fields();
      logic [31:0] d;
      wr(3, 2, 32'hFFFF_FFFF);
      rd(3, 2, d);
      checks++;
      if (d !== 32'hFFFF_FFFF) $display("FAIL period_full: got %h want ffffffff", d);
      else passed++;
      wr(3, 4, 32'h1234_5678);
      rd(3, 4, d);
      checks++;
      if (d !== 32'h0000_5678) $display("FAIL prescale_trunc: got %h want 00005678", d);
      else passed++;
      wr(3, 1, 32'hF);          // START and STOP: START wins
      rd(3, 1, d);
      checks++;
      if (d !== 32'h3) $display("FAIL control_bits: got %h want 3", d);
      else passed++;
      rd(3, 0, d);
      checks++;
      if (d !== 32'h2) $display("FAIL start_wins: got %h want 2", d);
      else passed++;
      wr(3, 1, 32'h8);
`ifndef MULTI_TIMER_PWM_EN
      wr(3, 5, 32'hAB);
      rd(3, 5, d);
      checks++;
      if (d !== 32'h0) $display("FAIL compare_absent: got %h want 0", d);
      else passed++;
`endif
   endtask

   task automatic test_period_zero();
      logic [31:0] d;
      wr(3, 4, 32'd0);
      wr(3, 2, 32'd0);
      wr(3, 1, 32'h7);          // S1
      tick(1);                  // S2 timeout
      checks++;
      if (irq_vec !== 4'b1000) $display("FAIL zero_first: vec=%b want 1000", irq_vec);
      else passed++;
      wr(3, 0, 32'd0);          // S3: timeout again, TO stays
      checks++;
      if (irq_vec !== 4'b1000) $display("FAIL zero_every_tick: vec=%b want 1000", irq_vec);
      else passed++;
      wr(3, 1, 32'h0);          // S4: ITO off (STOP not needed, CONT kept 0)
      wr(3, 1, 32'h8);          // stop
      wr(3, 0, 32'd0);
      rd(3, 0, d);
      checks++;
      if (d !== 32'h0 || irq !== 1'b0) $display("FAIL zero_stop: status=%h irq=%b want 0/0", d, irq);
      else passed++;
   endtask

   task automatic test_pwm();
      int highs;
`ifdef MULTI_TIMER_PWM_EN
      wr(0, 5, 32'd3);
      wr(0, 2, 32'd9);
      wr(0, 1, 32'h6);
      tick(3);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (pwm_out[0] === 1'b1) highs++;
      end
      checks++;
      if (highs !== 6) $display("FAIL pwm_duty: got %0d high of 20 want 6", highs);
      else passed++;
      checks++;
      if (pwm_out[3:1] !== 3'b000) $display("FAIL pwm_others: got %b want 000", pwm_out[3:1]);
      else passed++;
      wr(0, 1, 32'h8);
      tick(2);
      checks++;
      if (pwm_out !== 4'b0000) $display("FAIL pwm_stopped: got %b want 0000", pwm_out);
      else passed++;
`else
      wr(0, 2, 32'd9);
      wr(0, 1, 32'h6);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (pwm_out !== 4'b0000) highs++;
      end
      checks++;
      if (highs !== 0) $display("FAIL pwm_tied: %0d cycles nonzero want 0", highs);
      else passed++;
      wr(0, 1, 32'h8);
`endif
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      wr(1, 2, 32'd1);
      wr(1, 1, 32'h7);
      tick(3);
      checks++;
      if (irq !== 1'b1) $display("FAIL mid_pre_irq: got %b want 1", irq);
      else passed++;
      reset = 1'b1;
      tick(1);
      checks++;
      if (irq !== 1'b0 || irq_vec !== 4'b0000 || readdata !== 32'd0)
         $display("FAIL mid_reset: irq=%b vec=%b rd=%h want 0", irq, irq_vec, readdata);
      else passed++;
      reset = 1'b0;
      rd(1, 2, d);
      checks++;
      if (d !== 32'd99999) $display("FAIL mid_period: got %0d want 99999", d);
      else passed++;
      rd(1, 1, d);
      checks++;
      if (d !== 32'h0) $display("FAIL mid_control: got %h want 0", d);
      else passed++;
   endtask

   initial begin
      reset      = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      test_reset();
      test_periodic();
      test_oneshot();
      test_period_write();
      test_fields();
      test_period_zero();
      test_pwm();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
